// File: rtl/spin_lattice_sweeper_pkg.sv
// Shared types and sizing helpers for the spin-lattice sweeper.
package spin_lattice_sweeper_pkg;

  localparam int unsigned DefaultSize = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StEval,
    StDone
  } sweep_state_e;

  function automatic int unsigned idx_width(int unsigned size);
    return $clog2(size);
  endfunction

  function automatic int unsigned mag_width(int unsigned size);
    return $clog2(size * size) + 2;
  endfunction

  localparam int unsigned DefaultIdxWidth = idx_width(DefaultSize);
  localparam int unsigned DefaultMagWidth = mag_width(DefaultSize);

endpackage

// File: rtl/lattice_wrap_addr.sv
// Maps a lattice site to its four periodic-boundary neighbours.
module lattice_wrap_addr #(
  parameter int unsigned IdxWidth = 4
) (
  input  logic [IdxWidth-1:0] row_i,
  input  logic [IdxWidth-1:0] col_i,
  output logic [IdxWidth-1:0] left_row_o,
  output logic [IdxWidth-1:0] left_col_o,
  output logic [IdxWidth-1:0] right_row_o,
  output logic [IdxWidth-1:0] right_col_o,
  output logic [IdxWidth-1:0] top_row_o,
  output logic [IdxWidth-1:0] top_col_o,
  output logic [IdxWidth-1:0] bottom_row_o,
  output logic [IdxWidth-1:0] bottom_col_o
);

  // Edge length is a power of two, so modular wrap is plain overflow.
  assign left_row_o   = row_i;
  assign left_col_o   = col_i - 1'b1;
  assign right_row_o  = row_i;
  assign right_col_o  = col_i + 1'b1;
  assign top_row_o    = row_i - 1'b1;
  assign top_col_o    = col_i;
  assign bottom_row_o = row_i + 1'b1;
  assign bottom_col_o = col_i;

endmodule

// File: rtl/spin_lattice_sweeper.sv
// Raster-order sequential sweeper over a periodic Ising lattice; hands each site and its
// neighbours to an external spin-update stage and writes back the returned spin.
module spin_lattice_sweeper
  import spin_lattice_sweeper_pkg::*;
#(
  parameter int unsigned SIZE = DefaultSize,
  localparam int unsigned IW = idx_width(SIZE),
  localparam int unsigned MW = mag_width(SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          num_sweeps,
  output logic                 spin_val,
  output logic                 left,
  output logic                 right,
  output logic                 top,
  output logic                 bottom,
  output logic                 enable,
  input  logic                 final_spin_val,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          sweep_count,
  output logic signed [MW-1:0] magnetization,
  input  logic [IW-1:0]        rd_row,
  input  logic [IW-1:0]        rd_col,
  output logic                 rd_spin
);

  localparam logic signed [MW-1:0] MagStep = MW'(2);

  sweep_state_e state_q, state_d;
  logic [IW-1:0] row_q, row_d, col_q, col_d;
  logic [15:0] target_q, target_d, sweep_q, sweep_d;
  logic [SIZE*SIZE-1:0] lattice_q, lattice_d;
  logic signed [MW-1:0] mag_q, mag_d;
  logic spin_q, spin_d, left_q, left_d, right_q, right_d, top_q, top_d, bottom_q, bottom_d;

  logic [IW-1:0] lr, lc, rr, rc, tr, tc, br, bc;
  logic [2*IW-1:0] site_idx;

  lattice_wrap_addr #(
    .IdxWidth(IW)
  ) u_wrap (
    .row_i       (row_q),
    .col_i       (col_q),
    .left_row_o  (lr),
    .left_col_o  (lc),
    .right_row_o (rr),
    .right_col_o (rc),
    .top_row_o   (tr),
    .top_col_o   (tc),
    .bottom_row_o(br),
    .bottom_col_o(bc)
  );

  assign site_idx = {row_q, col_q};

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    target_d  = target_q;
    sweep_d   = sweep_q;
    lattice_d = lattice_q;
    mag_d     = mag_q;
    spin_d    = spin_q;
    left_d    = left_q;
    right_d   = right_q;
    top_d     = top_q;
    bottom_d  = bottom_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          target_d = num_sweeps;
          row_d    = '0;
          col_d    = '0;
          if (num_sweeps == 16'd0) begin
            state_d = StDone;
          end else begin
            sweep_d = '0;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        spin_d   = lattice_q[site_idx];
        left_d   = lattice_q[{lr, lc}];
        right_d  = lattice_q[{rr, rc}];
        top_d    = lattice_q[{tr, tc}];
        bottom_d = lattice_q[{br, bc}];
        state_d  = StEval;
      end
      StEval: begin
        lattice_d[site_idx] = final_spin_val;
        if (lattice_q[site_idx] != final_spin_val) begin
          mag_d = final_spin_val ? mag_q + MagStep : mag_q - MagStep;
        end
        col_d   = col_q + 1'b1;
        state_d = StFetch;
        if (col_q == '1) begin
          row_d = row_q + 1'b1;
          // Row and column both wrap to zero here, ready for the next sweep.
          if (row_q == '1) begin
            sweep_d = sweep_q + 16'd1;
            if (sweep_d == target_q) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      target_q  <= '0;
      sweep_q   <= '0;
      lattice_q <= '1;
      mag_q     <= MW'(SIZE * SIZE);
      spin_q    <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      top_q     <= 1'b0;
      bottom_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      target_q  <= target_d;
      sweep_q   <= sweep_d;
      lattice_q <= lattice_d;
      mag_q     <= mag_d;
      spin_q    <= spin_d;
      left_q    <= left_d;
      right_q   <= right_d;
      top_q     <= top_d;
      bottom_q  <= bottom_d;
    end
  end

  assign spin_val      = spin_q;
  assign left          = left_q;
  assign right         = right_q;
  assign top           = top_q;
  assign bottom        = bottom_q;
  assign enable        = (state_q == StEval);
  assign busy          = (state_q == StFetch) || (state_q == StEval);
  assign done          = (state_q == StDone);
  assign sweep_count   = sweep_q;
  assign magnetization = mag_q;
  assign rd_spin       = lattice_q[{rd_row, rd_col}];

endmodule

// File: tb/tb_spin_lattice_sweeper.sv
// Directed, table-driven bench for spin_lattice_sweeper at SIZE=4.
module tb_spin_lattice_sweeper;

  localparam int unsigned SIZE = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       num_sweeps;
  logic              spin_val, left, right, top, bottom, enable;
  logic              final_spin_val;
  logic              busy, done;
  logic [15:0]       sweep_count;
  logic signed [5:0] magnetization;
  logic [1:0]        rd_row, rd_col;
  logic              rd_spin;

  spin_lattice_sweeper #(
    .SIZE(SIZE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_sweeps    (num_sweeps),
    .spin_val      (spin_val),
    .left          (left),
    .right         (right),
    .top           (top),
    .bottom        (bottom),
    .enable        (enable),
    .final_spin_val(final_spin_val),
    .busy          (busy),
    .done          (done),
    .sweep_count   (sweep_count),
    .magnetization (magnetization),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_spin       (rd_spin)
  );

  always #5 clk = ~clk;

  // mode 0: return spin unchanged; 1: invert; 2: write 0 at (0,3) and (3,0), 1 elsewhere.
  typedef struct {
    int          ns;
    int          mode;
    int          restart_at;
    int          exp_lat;
    int          exp_mag;
    int          exp_sc;
    bit          chk_sc;
    logic [15:0] exp_lattice;
  } vec_t;

  vec_t vecs[8];
  bit   model[16];
  int   nvec = 0;
  int   nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lattice(input string name, input logic [15:0] exp);
    logic [15:0] got;
    for (int k = 0; k < 16; k++) begin
      rd_row = 2'(k / 4);
      rd_col = 2'(k % 4);
      #1;
      got[k] = rd_spin;
    end
    chk(name, int'(got), int'(exp));
  endtask

  task automatic run_vec(input vec_t v);
    int n, enables, k, r, c, fsv;
    bit seen_done;
    num_sweeps = 16'(v.ns);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    enables = 0;
    seen_done = 1'b0;
    while (!seen_done && n <= 2000) begin
      if (v.restart_at != 0) begin
        start = (n == v.restart_at);
        num_sweeps = (n == v.restart_at) ? 16'd7 : 16'(v.ns);
      end
      if (n == 1 && v.ns > 0) chk("busy_after_start", int'(busy), 1);
      if (enable) begin
        k = enables % 16;
        r = k / 4;
        c = k % 4;
        chk("spin_val", int'(spin_val), int'(model[k]));
        chk("left", int'(left), int'(model[r * 4 + (c + 3) % 4]));
        chk("right", int'(right), int'(model[r * 4 + (c + 1) % 4]));
        chk("top", int'(top), int'(model[((r + 3) % 4) * 4 + c]));
        chk("bottom", int'(bottom), int'(model[((r + 1) % 4) * 4 + c]));
        case (v.mode)
          0: fsv = int'(spin_val);
          1: fsv = int'(!spin_val);
          default: fsv = (k == 3 || k == 12) ? 0 : 1;
        endcase
        final_spin_val = fsv[0];
        model[k] = fsv[0];
        enables++;
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_latency", n, v.exp_lat);
        chk("busy_at_done", int'(busy), 0);
      end else begin
        step();
        n++;
      end
    end
    start = 1'b0;
    num_sweeps = 16'(v.ns);
    if (!seen_done) chk("done_timeout", 0, 1);
    chk("enable_count", enables, 16 * v.ns);
    step();
    chk("done_one_cycle", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    if (v.chk_sc) chk("sweep_count", int'(sweep_count), v.exp_sc);
    chk("magnetization", int'(magnetization), v.exp_mag);
    check_lattice("lattice", v.exp_lattice);
  endtask

  initial begin
    int dones;
    vecs[0] = '{1, 0, 0, 33, 16, 1, 1'b1, 16'hFFFF};
    vecs[1] = '{1, 1, 0, 33, -16, 1, 1'b1, 16'h0000};
    vecs[2] = '{2, 1, 0, 65, -16, 2, 1'b1, 16'h0000};
    vecs[3] = '{0, 1, 0, 1, -16, 0, 1'b0, 16'h0000};
    vecs[4] = '{3, 1, 0, 97, 16, 3, 1'b1, 16'hFFFF};
    vecs[5] = '{1, 2, 0, 33, 12, 1, 1'b1, 16'hEFF7};
    vecs[6] = '{1, 0, 10, 33, 12, 1, 1'b1, 16'hEFF7};
    vecs[7] = '{1, 1, 0, 33, -12, 1, 1'b1, 16'h1008};
    for (int k = 0; k < 16; k++) model[k] = 1'b1;

    rst = 1'b1;
    start = 1'b0;
    num_sweeps = '0;
    final_spin_val = 1'b0;
    rd_row = '0;
    rd_col = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_enable", int'(enable), 0);
    chk("reset_nbrs", int'({spin_val, left, right, top, bottom}), 0);
    chk("reset_sweep_count", int'(sweep_count), 0);
    chk("reset_mag", int'(magnetization), 16);
    check_lattice("reset_lattice", 16'hFFFF);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Abort a two-sweep run partway through the first sweep.
    num_sweeps = 16'd2;
    final_spin_val = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_enable", int'(enable), 0);
    chk("abort_nbrs", int'({spin_val, left, right, top, bottom}), 0);
    chk("abort_sweep_count", int'(sweep_count), 0);
    chk("abort_mag", int'(magnetization), 16);
    for (int i = 0; i < 80; i++) begin
      if (done || enable) dones++;
      step();
    end
    chk("abort_no_done", dones, 0);
    check_lattice("abort_lattice", 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
